// File: rtl/seq_match_monitor.sv
// seq_match_monitor: counts qualified detector matches and reports inter-match gaps over valid/ready.
module seq_match_monitor #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x_valid,
    input  logic             z,
    input  logic             clr,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat,
    output logic [GAP_W-1:0] gap_data,
    output logic             gap_valid,
    input  logic             gap_ready,
    output logic             drop_sticky
);
    typedef enum logic {IDLE, ARMED} state_t;
    state_t           state_q;
    logic [CNT_W-1:0] match_count_q, match_count_d;
    logic             count_sat_q;
    logic [GAP_W-1:0] gap_q, gap_d, gap_data_q;
    logic [GAP_W:0]   gap_inc;
    logic             gap_valid_q, drop_sticky_q, m, load;
    always_comb begin
        m             = z & x_valid;
        load          = m & (state_q == ARMED);
        gap_inc       = {1'b0, gap_q} + 1'b1;
        gap_d         = gap_inc[GAP_W] ? '1 : gap_inc[GAP_W-1:0];
        match_count_d = (match_count_q == '1) ? match_count_q : match_count_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state_q       <= IDLE;
            match_count_q <= '0;
            count_sat_q   <= 1'b0;
            gap_q         <= '0;
            gap_data_q    <= '0;
            gap_valid_q   <= 1'b0;
            drop_sticky_q <= 1'b0;
        end else begin
            if (m) begin
                match_count_q <= match_count_d;
                count_sat_q   <= count_sat_q | (match_count_d == '1);
                state_q       <= ARMED;
                gap_q         <= '0;
            end else if (x_valid && state_q == ARMED) begin
                gap_q <= gap_d;
            end
            // A stalled report is never overwritten; the new one is dropped instead.
            if (load && gap_valid_q && !gap_ready) begin
                drop_sticky_q <= 1'b1;
            end else if (load) begin
                gap_data_q  <= gap_d;
                gap_valid_q <= 1'b1;
            end else if (gap_valid_q && gap_ready) begin
                gap_valid_q <= 1'b0;
            end
        end
    end
    assign match_count = match_count_q;
    assign count_sat   = count_sat_q;
    assign gap_data    = gap_data_q;
    assign gap_valid   = gap_valid_q;
    assign drop_sticky = drop_sticky_q;
endmodule

// File: tb/tb_seq_match_monitor.sv
// tb_seq_match_monitor: directed checks of match counting, gap reporting, handshake, clr and reset.
module tb_seq_match_monitor;
    logic       clk = 1'b0, reset = 1'b1, x_valid = 1'b1, z = 1'b0, clr = 1'b0, gap_ready = 1'b1;
    logic [7:0] cnt8, gap8;
    logic [3:0] cnt4, gap4;
    logic       sat8, val8, drop8, sat4, val4, drop4;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    seq_match_monitor #(.CNT_W(8), .GAP_W(8)) u8 (
        .clk(clk), .reset(reset), .x_valid(x_valid), .z(z), .clr(clr),
        .match_count(cnt8), .count_sat(sat8), .gap_data(gap8), .gap_valid(val8),
        .gap_ready(gap_ready), .drop_sticky(drop8)
    );
    seq_match_monitor #(.CNT_W(4), .GAP_W(4)) u4 (
        .clk(clk), .reset(reset), .x_valid(x_valid), .z(z), .clr(clr),
        .match_count(cnt4), .count_sat(sat4), .gap_data(gap4), .gap_valid(val4),
        .gap_ready(gap_ready), .drop_sticky(drop4)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic xv, input logic zz);
        x_valid = xv;
        z = zz;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] p, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, p[i]);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1'b1, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        step(1'b1, 1'b0);
        pulse_reset();
        chk("rst_count", int'(cnt8), 0);
        chk("rst_sat", int'(sat8), 0);
        chk("rst_gap_data", int'(gap8), 0);
        chk("rst_gap_valid", int'(val8), 0);
        chk("rst_drop", int'(drop8), 0);
        // T1: stream 1011011 -> matches on bits 3 and 6
        feed(16'b0001, 4);
        chk("t1_count1", int'(cnt8), 1);
        chk("t1_no_first_report", int'(val8), 0);
        feed(16'b00, 2);
        chk("t1_still_no_report", int'(val8), 0);
        step(1'b1, 1'b1);
        chk("t1_count2", int'(cnt8), 2);
        chk("t1_valid", int'(val8), 1);
        chk("t1_gap3", int'(gap8), 3);
        step(1'b1, 1'b0);
        chk("t1_pulse_one_cycle", int'(val8), 0);
        // T2: stalled consumer, 1011011011
        pulse_reset();
        gap_ready = 1'b0;
        feed(16'b0001001001, 10);
        chk("t2_count3", int'(cnt8), 3);
        chk("t2_valid", int'(val8), 1);
        chk("t2_gap3", int'(gap8), 3);
        chk("t2_drop", int'(drop8), 1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("t2_held_valid", int'(val8), 1);
        chk("t2_held_data", int'(gap8), 3);
        gap_ready = 1'b1;
        step(1'b1, 1'b0);
        chk("t2_accept_drop_valid", int'(val8), 0);
        chk("t2_drop_sticky", int'(drop8), 1);
        // T3: gap saturation
        pulse_reset();
        step(1'b1, 1'b1);
        repeat (300) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("t3_gap_sat", int'(gap8), 255);
        chk("t3_valid", int'(val8), 1);
        chk("t3_gap4_sat", int'(gap4), 15);
        // T4: count saturation then clr
        pulse_reset();
        gap_ready = 1'b0;
        repeat (20) step(1'b1, 1'b1);
        chk("t4_cnt4_sat_val", int'(cnt4), 15);
        chk("t4_cnt4_sat_flag", int'(sat4), 1);
        chk("t4_cnt8", int'(cnt8), 20);
        chk("t4_sat8_clear", int'(sat8), 0);
        chk("t4_gap1", int'(gap8), 1);
        chk("t4_drop", int'(drop8), 1);
        clr = 1'b1;
        step(1'b1, 1'b0);
        clr = 1'b0;
        chk("t4_clr_cnt4", int'(cnt4), 0);
        chk("t4_clr_sat4", int'(sat4), 0);
        chk("t4_clr_valid", int'(val8), 0);
        chk("t4_clr_data", int'(gap8), 0);
        chk("t4_clr_drop", int'(drop8), 0);
        // T5: z ignored while x_valid low
        gap_ready = 1'b1;
        step(1'b1, 1'b1);
        chk("t5_count1", int'(cnt8), 1);
        repeat (5) step(1'b0, 1'b1);
        chk("t5_count_hold", int'(cnt8), 1);
        chk("t5_no_report", int'(val8), 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("t5_count2", int'(cnt8), 2);
        chk("t5_valid", int'(val8), 1);
        chk("t5_gap_unaffected", int'(gap8), 3);
        // T6: clr beats match; reset drops pending report
        step(1'b1, 1'b0);
        clr = 1'b1;
        step(1'b1, 1'b1);
        clr = 1'b0;
        chk("t6_clr_match_count", int'(cnt8), 0);
        step(1'b1, 1'b1);
        chk("t6_first_count", int'(cnt8), 1);
        chk("t6_first_no_report", int'(val8), 0);
        gap_ready = 1'b0;
        step(1'b1, 1'b1);
        chk("t6_valid", int'(val8), 1);
        chk("t6_gap1", int'(gap8), 1);
        pulse_reset();
        chk("t6_reset_valid", int'(val8), 0);
        chk("t6_reset_count", int'(cnt8), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
